// File: rtl/ysyx_24080014_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24080014_pkg
// Shared definitions for the IFU/LSU memory arbiter: bus widths, arbiter FSM
// state encoding and the requester ID encoding used by the round-robin picker.
// ----------------------------------------------------------------------------
package ysyx_24080014_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_IFU  = 3'd1,
        ST_REQ_LSU  = 3'd2,
        ST_WAIT_IFU = 3'd3,
        ST_WAIT_LSU = 3'd4
    } state_e;

    typedef enum logic {
        ID_IFU = 1'b0,
        ID_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/ysyx_24080014_rr_sel.sv
// ----------------------------------------------------------------------------
// ysyx_24080014_rr_sel
// Two-way round-robin picker. On a tie the requester that did not win last
// time is chosen; otherwise the single valid requester wins.
// Ports:
//   i_ifu_valid   fetch request pending
//   i_lsu_valid   load/store request pending
//   i_last_grant  requester granted most recently
//   o_grant       chosen requester (meaningless when neither is valid)
// ----------------------------------------------------------------------------
module ysyx_24080014_rr_sel
    import ysyx_24080014_pkg::*;
(
    input  logic    i_ifu_valid,
    input  logic    i_lsu_valid,
    input  req_id_e i_last_grant,
    output req_id_e o_grant
);

    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        o_grant = ID_LSU;
        if (i_ifu_valid && i_lsu_valid) begin
            if (i_last_grant == ID_IFU) begin
                o_grant = ID_LSU;
            end else begin
                o_grant = ID_IFU;
            end
        end else if (i_ifu_valid) begin
            o_grant = ID_IFU;
        end
    end

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24080014_mem_arbiter
// Shares one memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). At most one transaction is in flight; ties are broken
// round-robin. Request fields and response data pass through combinationally
// while the owning requester's transaction is in the matching state.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifu_req_*             fetch request (valid/addr in, ready out)
//   ifu_resp_*            fetch response (valid pulse, rdata)
//   lsu_req_*             load/store request (valid/wen/addr/wdata/wmask in, ready out)
//   lsu_resp_*            load/store response (valid pulse, rdata)
//   mem_req_*             shared memory request (valid/wen/addr/wdata/wmask out, ready in)
//   mem_resp_*            memory response (valid, rdata in; no backpressure)
// ----------------------------------------------------------------------------
module ysyx_24080014_mem_arbiter
    import ysyx_24080014_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_req_ready,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_rdata,

    input  logic              lsu_req_valid,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_req_ready,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_rdata,

    output logic              mem_req_valid,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    state_e  r_state;
    req_id_e r_last_grant;
    req_id_e w_grant;

    ysyx_24080014_rr_sel u_rr_sel (
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Arbitration happens only in IDLE; once a requester owns the port it
    // keeps it through the request and response phases.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= ID_LSU;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (ifu_req_valid || lsu_req_valid) begin
                        r_last_grant <= w_grant;
                        r_state      <= (w_grant == ID_IFU) ? ST_REQ_IFU : ST_REQ_LSU;
                    end
                end
                ST_REQ_IFU: begin
                    if (mem_req_ready) r_state <= ST_WAIT_IFU;
                end
                ST_REQ_LSU: begin
                    if (mem_req_ready) r_state <= ST_WAIT_LSU;
                end
                ST_WAIT_IFU: begin
                    if (mem_resp_valid) r_state <= ST_IDLE;
                end
                ST_WAIT_LSU: begin
                    if (mem_resp_valid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode. Everything is forced quiet while rst is high so that an
    // abandoned transaction cannot leak a handshake or response during reset.
    always_comb begin
        mem_req_valid  = 1'b0;
        mem_req_wen    = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        mem_req_wmask  = '0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        if (!rst) begin
            unique case (r_state)
                ST_REQ_IFU: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = ifu_req_addr;
                    ifu_req_ready = mem_req_ready;
                end
                ST_REQ_LSU: begin
                    mem_req_valid = 1'b1;
                    mem_req_wen   = lsu_req_wen;
                    mem_req_addr  = lsu_req_addr;
                    mem_req_wdata = lsu_req_wdata;
                    mem_req_wmask = lsu_req_wmask;
                    lsu_req_ready = mem_req_ready;
                end
                ST_WAIT_IFU: begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_resp_rdata = mem_resp_rdata;
                end
                ST_WAIT_LSU: begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_resp_rdata = mem_resp_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24080014_mem_arbiter
// Directed bench for the IFU/LSU memory arbiter. Expected responses are queued
// when requests are driven and popped whenever a response pulse appears.
// ----------------------------------------------------------------------------
module tb_ysyx_24080014_mem_arbiter;
    import ysyx_24080014_pkg::*;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    ysyx_24080014_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_rdata (ifu_resp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        req_id_e     id;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Outputs captured at the falling edge of the cycle just completed.
    logic        s_mem_req_valid, s_mem_req_wen;
    logic [31:0] s_mem_req_addr, s_mem_req_wdata;
    logic [3:0]  s_mem_req_wmask;
    logic        s_ifu_ready, s_lsu_ready, s_ifu_rv, s_lsu_rv;
    logic [31:0] s_ifu_rdata, s_lsu_rdata;

    // Requesters must hold valid until accepted.
    logic r_ifu_pend = 1'b0;
    logic r_lsu_pend = 1'b0;
    always @(posedge clk) begin
        if (!rst && r_ifu_pend) assert (ifu_req_valid) else $error("FAIL protocol_ifu: valid dropped before ready");
        if (!rst && r_lsu_pend) assert (lsu_req_valid) else $error("FAIL protocol_lsu: valid dropped before ready");
        r_ifu_pend <= !rst && ifu_req_valid && !ifu_req_ready;
        r_lsu_pend <= !rst && lsu_req_valid && !lsu_req_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input req_id_e id, input logic chk, input logic [31:0] rdata);
        exp_t e;
        e.id    = id;
        e.chk   = chk;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Advance one cycle: sample outputs, score any response, then play the
    // requester role by dropping a request once it was accepted.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        s_mem_req_valid = mem_req_valid;
        s_mem_req_wen   = mem_req_wen;
        s_mem_req_addr  = mem_req_addr;
        s_mem_req_wdata = mem_req_wdata;
        s_mem_req_wmask = mem_req_wmask;
        s_ifu_ready     = ifu_req_ready;
        s_lsu_ready     = lsu_req_ready;
        s_ifu_rv        = ifu_resp_valid;
        s_lsu_rv        = lsu_resp_valid;
        s_ifu_rdata     = ifu_resp_rdata;
        s_lsu_rdata     = lsu_resp_rdata;
        if (s_ifu_rv || s_lsu_rv) begin
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_owner", 32'(s_lsu_rv), 32'(e.id));
                check("resp_exclusive", 32'(s_ifu_rv & s_lsu_rv), 32'd0);
                if (e.chk) check("resp_rdata", s_lsu_rv ? s_lsu_rdata : s_ifu_rdata, e.rdata);
            end
        end
        @(posedge clk);
        #1;
        if (s_ifu_ready) begin
            ifu_req_valid = 1'b0;
            ifu_req_addr  = '0;
        end
        if (s_lsu_ready) begin
            lsu_req_valid = 1'b0;
            lsu_req_wen   = 1'b0;
            lsu_req_addr  = '0;
            lsu_req_wdata = '0;
            lsu_req_wmask = '0;
        end
    endtask

    // Called in the first REQ_x cycle: stall, handshake, wait, respond.
    task automatic serve(input req_id_e id, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input int stall, input int lat, input logic [31:0] rdata);
        logic [1:0] own;
        own = (id == ID_IFU) ? 2'b10 : 2'b01;
        mem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            cyc();
            check("stall_valid", 32'(s_mem_req_valid), 32'd1);
            check("stall_addr", s_mem_req_addr, addr);
            check("stall_wdata", s_mem_req_wdata, wdata);
            check("stall_ready", 32'({s_ifu_ready, s_lsu_ready}), 32'd0);
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        check("hs_valid", 32'(s_mem_req_valid), 32'd1);
        check("hs_addr", s_mem_req_addr, addr);
        check("hs_wen", 32'(s_mem_req_wen), 32'(wen));
        check("hs_wdata", s_mem_req_wdata, wdata);
        check("hs_wmask", 32'(s_mem_req_wmask), 32'(wmask));
        check("hs_ready", 32'({s_ifu_ready, s_lsu_ready}), 32'(own));
        for (int i = 1; i < lat; i++) begin
            cyc();
            check("wait_valid", 32'(s_mem_req_valid), 32'd0);
            check("wait_addr", s_mem_req_addr, 32'd0);
            check("wait_ready", 32'({s_ifu_ready, s_lsu_ready}), 32'd0);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        cyc();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        check("resp_valid", 32'({s_ifu_rv, s_lsu_rv}), 32'(own));
        check("resp_req_valid", 32'(s_mem_req_valid), 32'd0);
        check("resp_ready", 32'({s_ifu_ready, s_lsu_ready}), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        lsu_req_valid  = 1'b0;
        lsu_req_wen    = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: outputs quiet, stray response ignored.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        cyc();
        check("rst_mem_valid", 32'(s_mem_req_valid), 32'd0);
        check("rst_mem_addr", s_mem_req_addr, 32'd0);
        check("rst_ready", 32'({s_ifu_ready, s_lsu_ready}), 32'd0);
        check("rst_resp", 32'({s_ifu_rv, s_lsu_rv}), 32'd0);
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        cyc();
        mem_resp_valid = 1'b1;
        cyc();
        mem_resp_valid = 1'b0;
        check("idle_late_resp", 32'({s_ifu_rv, s_lsu_rv}), 32'd0);

        // First tie after reset: IFU then LSU, then tie again -> IFU.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_1000;
        push(ID_IFU, 1'b1, 32'h1111_1111);
        push(ID_LSU, 1'b1, 32'h2222_2222);
        cyc();
        check("tie_idle", 32'(s_mem_req_valid), 32'd0);
        serve(ID_IFU, 32'h8000_0004, 1'b0, 32'd0, 4'd0, 0, 1, 32'h1111_1111);
        cyc();
        check("b2b_gap", 32'(s_mem_req_valid), 32'd0);
        serve(ID_LSU, 32'h8000_1000, 1'b0, 32'd0, 4'd0, 0, 1, 32'h2222_2222);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1004;
        push(ID_IFU, 1'b1, 32'h3333_3333);
        push(ID_LSU, 1'b1, 32'h4444_4444);
        cyc();
        serve(ID_IFU, 32'h8000_0008, 1'b0, 32'd0, 4'd0, 0, 1, 32'h3333_3333);
        cyc();
        serve(ID_LSU, 32'h8000_1004, 1'b0, 32'd0, 4'd0, 0, 2, 32'h4444_4444);

        // IFU alone: request one cycle later, response two cycles after handshake.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        push(ID_IFU, 1'b1, 32'h0000_0413);
        cyc();
        check("ifu_cycle0", 32'(s_mem_req_valid), 32'd0);
        serve(ID_IFU, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 0, 2, 32'h0000_0413);
        cyc();
        check("ifu_pulse", 32'({s_ifu_rv, s_lsu_rv}), 32'd0);

        // Tie with IFU granted last: LSU wins first.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1008;
        push(ID_LSU, 1'b1, 32'h6666_6666);
        push(ID_IFU, 1'b1, 32'h7777_7777);
        cyc();
        serve(ID_LSU, 32'h8000_1008, 1'b0, 32'd0, 4'd0, 0, 1, 32'h6666_6666);
        cyc();
        serve(ID_IFU, 32'h8000_0010, 1'b0, 32'd0, 4'd0, 0, 1, 32'h7777_7777);

        // Stalled store with a fetch arriving meanwhile: no switch.
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_2000;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
        push(ID_LSU, 1'b0, 32'd0);
        cyc();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_000C;
        push(ID_IFU, 1'b1, 32'h5555_5555);
        serve(ID_LSU, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 1, 32'h0BAD_0BAD);
        cyc();
        check("store_gap", 32'(s_mem_req_valid), 32'd0);
        serve(ID_IFU, 32'h8000_000C, 1'b0, 32'd0, 4'd0, 0, 1, 32'h5555_5555);

        // Responses in IDLE and REQ_IFU are ignored.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0014;
        push(ID_IFU, 1'b1, 32'h8888_8888);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_0001;
        cyc();
        check("idle_resp_drop", 32'({s_ifu_rv, s_lsu_rv}), 32'd0);
        mem_req_ready = 1'b0;
        cyc();
        check("req_resp_drop", 32'({s_ifu_rv, s_lsu_rv}), 32'd0);
        check("req_resp_valid", 32'(s_mem_req_valid), 32'd1);
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        serve(ID_IFU, 32'h8000_0014, 1'b0, 32'd0, 4'd0, 0, 1, 32'h8888_8888);

        // Reset in WAIT_LSU abandons the load.
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_3000;
        cyc();
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        check("abort_hs", 32'(s_lsu_ready), 32'd1);
        rst = 1'b1;
        cyc();
        check("abort_rst_out", 32'({s_mem_req_valid, s_ifu_ready, s_lsu_ready, s_ifu_rv, s_lsu_rv}), 32'd0);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_0000;
        cyc();
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        check("abort_no_resp", 32'(s_lsu_rv), 32'd0);
        check("abort_idle", 32'(s_mem_req_valid), 32'd0);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0018;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_300C;
        push(ID_IFU, 1'b1, 32'h9999_9999);
        push(ID_LSU, 1'b1, 32'hAAAA_AAAA);
        cyc();
        serve(ID_IFU, 32'h8000_0018, 1'b0, 32'd0, 4'd0, 0, 1, 32'h9999_9999);
        cyc();
        serve(ID_LSU, 32'h8000_300C, 1'b0, 32'd0, 4'd0, 0, 1, 32'hAAAA_AAAA);
        cyc();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_mem_arbiter.md
YSYX_24080014_MEM_ARBITER -- requirements
Module: ysyx_24080014_mem_arbiter

Interface
REQ-001 No parameters; address and data widths SHALL be fixed at 32 bits, wmask at 4 bits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ifu_req_valid  in  1  fetch request present; held until accepted.
REQ-005 ifu_req_addr  in  32  fetch address (pc).
REQ-006 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 ifu_resp_valid  out  1  one-cycle pulse; ifu_resp_rdata valid.
REQ-008 ifu_resp_rdata  out  32  fetched instruction word.
REQ-009 lsu_req_valid  in  1  load/store request present; held until accepted.
REQ-010 lsu_req_wen  in  1  1 = store, 0 = load.
REQ-011 lsu_req_addr  in  32  load/store address.
REQ-012 lsu_req_wdata  in  32  store data.
REQ-013 lsu_req_wmask  in  4  store byte enables.
REQ-014 lsu_req_ready  out  1  lsu request accepted this cycle.
REQ-015 lsu_resp_valid  out  1  one-cycle pulse; load data or store ack.
REQ-016 lsu_resp_rdata  out  32  load data (don't-care for stores).
REQ-017 mem_req_valid / mem_req_wen / mem_req_addr / mem_req_wdata / mem_req_wmask  out  1/1/32/32/4  shared memory request.
REQ-018 mem_req_ready  in  1  memory accepts request.
REQ-019 mem_resp_valid / mem_resp_rdata  in  1/32  memory response; no backpressure.

Function
REQ-020 FSM states SHALL be IDLE, REQ_IFU, REQ_LSU, WAIT_IFU, WAIT_LSU; at most one transaction outstanding.
REQ-021 IDLE: only ifu valid -> REQ_IFU; only lsu valid -> REQ_LSU; both valid -> the requester not in last_grant; neither -> stay in IDLE.
REQ-022 last_grant SHALL update to the chosen requester on each IDLE->REQ_x transition; its reset value is LSU, so the first tie grants IFU.
REQ-023 REQ_x: mem_req_valid=1; mem_req_addr/wen/wdata/wmask pass combinationally from owner x; for IFU, wen=0, wdata=0, wmask=0.
REQ-024 REQ_x: x_req_ready = mem_req_ready; the other requester's ready=0; on handshake go to WAIT_x, otherwise hold REQ_x and do not re-arbitrate.
REQ-025 In IDLE, WAIT_IFU and WAIT_LSU: mem_req_valid=0 and both req_ready=0; mem_req_* data outputs SHALL be 0.
REQ-026 WAIT_x: x_resp_valid = mem_resp_valid and x_resp_rdata = mem_resp_rdata, combinationally; on mem_resp_valid go to IDLE.
REQ-027 The non-owner resp_valid SHALL be 0 in every state; mem_resp_valid outside WAIT_x SHALL be ignored.
REQ-028 Latency: req_valid to mem_req_valid is 1 cycle; response path adds 0 cycles; back-to-back transactions SHALL be spaced by exactly one IDLE cycle.
REQ-029 Requester valid dropping before ready is a protocol violation; behaviour is undefined and is flagged by a bench assertion.

Reset
REQ-030 rst=1 SHALL force IDLE and last_grant=LSU at the next edge from any state; any outstanding transaction is abandoned.
REQ-031 During and after reset: all ready, resp_valid and mem_req_* outputs SHALL be 0; a late mem_resp_valid arriving in IDLE SHALL be dropped.

Structure
REQ-032 Shared package ysyx_24080014_pkg SHALL hold the state encoding, the requester ID encoding (IFU=0, LSU=1), and the width constants.
REQ-033 The two-way round-robin picker SHALL be a sub-module ysyx_24080014_rr_sel (inputs: two valids and last_grant; output: grant ID); everything else stays flat.

Verification
REQ-034 IFU only, addr 0x80000000, mem ready immediately, resp 0x00000413 two cycles later -> mem_req_valid at cycle 1, ifu_resp_valid one pulse with rdata 0x00000413, lsu_resp_valid never set.
REQ-035 Both valid after reset (IFU 0x80000004, LSU load 0x80001000) -> IFU served first, then LSU; next tie -> IFU served (alternation).
REQ-036 LSU store 0x80002000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low for 3 cycles -> request held stable, no switch to a pending IFU request, lsu_req_ready pulses once.
REQ-037 rst asserted in WAIT_LSU, then mem_resp_valid one cycle later -> FSM in IDLE, lsu_resp_valid stays 0, next tie grants IFU.
REQ-038 mem_resp_valid injected in IDLE and REQ_IFU -> no resp_valid output to either requester.
